// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared types, constants and byte-merge helper for regfile_mp
//
// Purpose : FSM state type, default geometry and the lane-merge function
//           used by both the write path and the bypass path.
// Ports   : none (package)

package regfile_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } regfile_state_t;

  localparam int RF_DATA_WIDTH = 32;
  localparam int RF_WORDS      = 32;

  // Widest word the merge helper handles. Callers zero-extend into this
  // width and truncate the result back, so one function serves any
  // DATA_WIDTH up to this bound.
  localparam int RF_MAX_DATA_WIDTH = 256;
  localparam int RF_MAX_LANES      = RF_MAX_DATA_WIDTH / 8;

  // Returns old_word with every byte lane whose strobe bit is set replaced
  // by the matching lane of new_word.
  function automatic logic [RF_MAX_DATA_WIDTH-1:0] rf_merge_bytes(
    input logic [RF_MAX_DATA_WIDTH-1:0] old_word,
    input logic [RF_MAX_DATA_WIDTH-1:0] new_word,
    input logic [RF_MAX_LANES-1:0]      be
  );
    logic [RF_MAX_DATA_WIDTH-1:0] merged;
    merged = old_word;
    for (int b = 0; b < RF_MAX_LANES; b++) begin
      if (be[b]) begin
        merged[8*b +: 8] = new_word[8*b +: 8];
      end
    end
    return merged;
  endfunction

endpackage

// File: rtl/regfile_clear_ctrl.sv
// rtl/regfile_clear_ctrl.sv - clear sequencer FSM and word counter for regfile_mp
//
// Purpose : Walks every bank address once after reset or on clear_i,
//           requesting a zero write per edge, then parks in READY.
// Ports   : clk_i    - clock, rising edge
//           rst_ni   - asynchronous active-low reset
//           clear_i  - restart the clear walk (from READY or mid-walk)
//           busy     - high while the walk is in progress
//           clr_we   - zero-write request for the bank write mux
//           clr_addr - address being zeroed this edge

module regfile_clear_ctrl
  import regfile_pkg::*;
#(
  parameter int WORDS       = RF_WORDS,
  parameter int SELECT_SIZE = $clog2(WORDS)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   clear_i,
  output logic                   busy,
  output logic                   clr_we,
  output logic [SELECT_SIZE-1:0] clr_addr
);

  localparam logic [SELECT_SIZE-1:0] LAST_ADDR = SELECT_SIZE'(WORDS - 1);

  regfile_state_t         state;
  regfile_state_t         state_nxt;
  logic [SELECT_SIZE-1:0] count;
  logic [SELECT_SIZE-1:0] count_nxt;

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    case (state)
      CLEAR: begin
        // A fresh clear request mid-walk starts over so the whole bank is
        // guaranteed zero when busy finally drops.
        if (clear_i) begin
          count_nxt = '0;
        end else if (count == LAST_ADDR) begin
          state_nxt = READY;
          count_nxt = '0;
        end else begin
          count_nxt = count + 1'b1;
        end
      end
      READY: begin
        if (clear_i) begin
          state_nxt = CLEAR;
          count_nxt = '0;
        end
      end
      default: begin
        state_nxt = CLEAR;
        count_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= CLEAR;
      count <= '0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
    end
  end

  assign busy     = (state == CLEAR);
  assign clr_we   = busy;
  assign clr_addr = count;

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-read-port register file with byte strobes and clear sequencer
//
// Purpose : WORDS x DATA_WIDTH bank, one byte-strobed write port,
//           READ_PORTS combinational read ports, optional x0 hardwiring.
//           Optional same-cycle write forwarding: REGFILE_BYPASS_EN.
// Ports   : clk_i, rst_ni  - clock, asynchronous active-low reset
//           clear_i        - request to re-zero the whole bank
//           reg_we_i       - write enable, active low
//           reg_be_i       - byte-lane write strobe, active high
//           reg_dst_i      - write address
//           data_i         - write data
//           reg_src_i      - packed read addresses, port 0 in the LSBs
//           src_o          - packed read data, port 0 in the LSBs
//           busy_o         - high while the clear walk runs

module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH  = RF_DATA_WIDTH,
  parameter int WORDS       = RF_WORDS,
  parameter int SELECT_SIZE = $clog2(WORDS),
  parameter int READ_PORTS  = 2,
  parameter int ZERO_REG    = 1
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              clear_i,
  input  logic                              reg_we_i,
  input  logic [DATA_WIDTH/8-1:0]           reg_be_i,
  input  logic [SELECT_SIZE-1:0]            reg_dst_i,
  input  logic [DATA_WIDTH-1:0]             data_i,
  input  logic [READ_PORTS*SELECT_SIZE-1:0] reg_src_i,
  output logic [READ_PORTS*DATA_WIDTH-1:0]  src_o,
  output logic                              busy_o
);

  // One extra bit so WORDS itself is representable when comparing selects
  // against the depth of a non-power-of-two bank.
  localparam logic [SELECT_SIZE:0] DEPTH = (SELECT_SIZE + 1)'(WORDS);

  logic [DATA_WIDTH-1:0] bank [WORDS];

  logic                   busy;
  logic                   ready;
  logic                   clr_we;
  logic [SELECT_SIZE-1:0] clr_addr;

  regfile_clear_ctrl #(
    .WORDS       (WORDS),
    .SELECT_SIZE (SELECT_SIZE)
  ) u_clear_ctrl (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .clear_i  (clear_i),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  assign ready  = ~busy;
  assign busy_o = busy;

  // Write path
  logic                  dst_ok;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_old;
  logic [DATA_WIDTH-1:0] wr_word;

  always_comb begin
    dst_ok = ({1'b0, reg_dst_i} < DEPTH) &&
             !((ZERO_REG != 0) && (reg_dst_i == '0));
    // clear_i wins over a same-cycle write; an all-zero strobe is a no-op.
    wr_en  = ready && !reg_we_i && !clear_i && dst_ok && (|reg_be_i);
    wr_old = dst_ok ? bank[reg_dst_i] : '0;
    wr_word = DATA_WIDTH'(rf_merge_bytes(RF_MAX_DATA_WIDTH'(wr_old),
                                         RF_MAX_DATA_WIDTH'(data_i),
                                         RF_MAX_LANES'(reg_be_i)));
  end

  // Storage carries no reset; the clear walk is what zeroes it.
  always_ff @(posedge clk_i) begin
    if (clr_we) begin
      bank[clr_addr] <= '0;
    end else if (wr_en) begin
      bank[reg_dst_i] <= wr_word;
    end
  end

  // Read ports
  for (genvar p = 0; p < READ_PORTS; p++) begin : g_rd
    logic [SELECT_SIZE-1:0] sel;
    logic                   sel_ok;
    logic [DATA_WIDTH-1:0]  stored;

    assign sel    = reg_src_i[p*SELECT_SIZE +: SELECT_SIZE];
    assign sel_ok = ready && ({1'b0, sel} < DEPTH) &&
                    !((ZERO_REG != 0) && (sel == '0));
    assign stored = sel_ok ? bank[sel] : '0;

`ifdef REGFILE_BYPASS_EN
    // wr_en already excludes dropped writes and x0, so a matching select
    // sees the strobed lanes of data_i over its stored word.
    assign src_o[p*DATA_WIDTH +: DATA_WIDTH] =
      (wr_en && (sel == reg_dst_i)) ?
        DATA_WIDTH'(rf_merge_bytes(RF_MAX_DATA_WIDTH'(stored),
                                   RF_MAX_DATA_WIDTH'(data_i),
                                   RF_MAX_LANES'(reg_be_i))) :
        stored;
`else
    assign src_o[p*DATA_WIDTH +: DATA_WIDTH] = stored;
`endif
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - self-checking bench for regfile_mp (32x32/2-port/x0 and 24x32/4-port instances)

module tb_regfile_mp;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic        we_n  = 1'b1;
  logic [3:0]  be    = 4'h0;
  logic [4:0]  dst   = 5'd0;
  logic [31:0] din   = 32'h0;
  logic [19:0] src   = 20'h0;

  logic [63:0]  src_o0;
  logic [127:0] src_o1;
  logic         busy0;
  logic         busy1;

  regfile_mp #(.DATA_WIDTH(32), .WORDS(32), .READ_PORTS(2), .ZERO_REG(1)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .reg_we_i(we_n), .reg_be_i(be),
    .reg_dst_i(dst), .data_i(din), .reg_src_i(src[9:0]), .src_o(src_o0), .busy_o(busy0)
  );

  regfile_mp #(.DATA_WIDTH(32), .WORDS(24), .READ_PORTS(4), .ZERO_REG(0)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .reg_we_i(we_n), .reg_be_i(be),
    .reg_dst_i(dst), .data_i(din), .reg_src_i(src), .src_o(src_o1), .busy_o(busy1)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: word contents plus the number of edges left until ready.
  logic [31:0] m0 [32];
  logic [31:0] m1 [24];
  int          rem0 = 32;
  int          rem1 = 24;

  logic [63:0]  q0;
  logic [127:0] q1;
  logic         qb0;
  logic         qb1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, want);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] b);
    logic [31:0] mask;
    mask = {{8{b[3]}}, {8{b[2]}}, {8{b[1]}}, {8{b[0]}}};
    return (o & ~mask) | (n & mask);
  endfunction

  function automatic logic wr_act(input int inst);
    int words;
    int rem;
    words = (inst != 0) ? 24 : 32;
    rem   = (inst != 0) ? rem1 : rem0;
    return rst_n && (rem == 0) && !we_n && !clear && (int'(dst) < words) &&
           !((inst == 0) && (dst == 5'd0)) && (be != 4'h0);
  endfunction

  function automatic logic [31:0] exp_rd(input int inst, input logic [4:0] sel);
    int          words;
    int          rem;
    logic [31:0] v;
    words = (inst != 0) ? 24 : 32;
    rem   = (inst != 0) ? rem1 : rem0;
    if (rem > 0 || int'(sel) >= words || ((inst == 0) && sel == 5'd0)) return 32'h0;
    v = (inst != 0) ? m1[sel] : m0[sel];
`ifdef REGFILE_BYPASS_EN
    if (wr_act(inst) && sel == dst) v = merge(v, din, be);
`endif
    return v;
  endfunction

  task automatic zero_models();
    for (int i = 0; i < 32; i++) m0[i] = 32'h0;
    for (int i = 0; i < 24; i++) m1[i] = 32'h0;
  endtask

  // One clock cycle: drive inputs after the falling edge, check against the
  // model, then advance the model across the rising edge.
  task automatic cyc(input logic r, input logic c, input logic w, input logic [3:0] b,
                     input logic [4:0] d, input logic [31:0] x, input logic [19:0] s);
    logic act0;
    logic act1;
    @(negedge clk);
    rst_n = r; clear = c; we_n = w; be = b; dst = d; din = x; src = s;
    if (!r) begin
      rem0 = 32;
      rem1 = 24;
      zero_models();
    end
    #1;
    q0 = src_o0; q1 = src_o1; qb0 = busy0; qb1 = busy1;
    chk("busy0", {31'b0, qb0}, {31'b0, rem0 > 0});
    chk("busy1", {31'b0, qb1}, {31'b0, rem1 > 0});
    for (int p = 0; p < 2; p++)
      chk($sformatf("dut0_port%0d_sel%0d", p, s[p*5 +: 5]), q0[p*32 +: 32], exp_rd(0, s[p*5 +: 5]));
    for (int p = 0; p < 4; p++)
      chk($sformatf("dut1_port%0d_sel%0d", p, s[p*5 +: 5]), q1[p*32 +: 32], exp_rd(1, s[p*5 +: 5]));
    act0 = wr_act(0);
    act1 = wr_act(1);
    @(posedge clk);
    if (r) begin
      if (rem0 > 0) rem0 = c ? 32 : rem0 - 1;
      else if (c) begin rem0 = 32; for (int i = 0; i < 32; i++) m0[i] = 32'h0; end
      else if (act0) m0[d] = merge(m0[d], x, b);
      if (rem1 > 0) rem1 = c ? 24 : rem1 - 1;
      else if (c) begin rem1 = 24; for (int i = 0; i < 24; i++) m1[i] = 32'h0; end
      else if (act1) m1[d] = merge(m1[d], x, b);
    end
  endtask

  function automatic logic [4:0] rsel();
    if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
    return 5'($urandom_range(0, 7));
  endfunction

  int n;

  initial begin
    zero_models();

    // Reset state
    cyc(1'b0, 1'b0, 1'b1, 4'h0, 5'd0, 32'h0, {5'd3, 5'd2, 5'd1, 5'd0});
    chk("rst_busy", {31'b0, qb0}, 32'd1);
    chk("rst_src", q0[31:0], 32'h0);
    cyc(1'b0, 1'b0, 1'b1, 4'h0, 5'd0, 32'h0, {5'd3, 5'd2, 5'd1, 5'd0});

    // Power-up clear walk: busy for exactly 32 cycles
    for (int i = 0; i < 32; i++) begin
      cyc(1'b1, 1'b0, 1'b1, 4'h0, 5'd0, 32'h0, {5'd3, 5'd2, 5'd1, 5'd0});
      chk("clr_busy_hi", {31'b0, qb0}, 32'd1);
    end
    cyc(1'b1, 1'b0, 1'b1, 4'h0, 5'd0, 32'h0, {5'd3, 5'd2, 5'd1, 5'd0});
    chk("clr_busy_lo", {31'b0, qb0}, 32'd0);
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, 1'b0, 1'b1, 4'h0, 5'd0, 32'h0, {10'd0, 5'(2*i+1), 5'(2*i)});
      chk("clr_zero_a", q0[31:0], 32'h0);
      chk("clr_zero_b", q0[63:32], 32'h0);
    end

    // Byte-lane writes
    cyc(1'b1, 1'b0, 1'b0, 4'hF, 5'd5, 32'hDEADBEEF, {4{5'd5}});
    cyc(1'b1, 1'b0, 1'b0, 4'h1, 5'd5, 32'h00000011, {4{5'd5}});
    cyc(1'b1, 1'b0, 1'b1, 4'h0, 5'd0, 32'h0, {4{5'd5}});
    chk("be_merge", q0[31:0], 32'hDEADBE11);
    chk("be_merge_24", q1[63:32], 32'hDEADBE11);
    cyc(1'b1, 1'b0, 1'b0, 4'h0, 5'd5, 32'hFFFFFFFF, {4{5'd5}});
    cyc(1'b1, 1'b0, 1'b1, 4'h0, 5'd0, 32'h0, {4{5'd5}});
    chk("be_none", q0[31:0], 32'hDEADBE11);

    // Register 0
    cyc(1'b1, 1'b0, 1'b0, 4'hF, 5'd0, 32'hFFFFFFFF, {4{5'd0}});
    cyc(1'b1, 1'b0, 1'b1, 4'h0, 5'd0, 32'h0, {4{5'd0}});
    chk("x0_zero_reg1", q0[31:0], 32'h0);
    chk("x0_zero_reg0", q1[31:0], 32'hFFFFFFFF);

    // clear_i together with a write: write dropped, 32 busy cycles
    cyc(1'b1, 1'b0, 1'b0, 4'hF, 5'd7, 32'h12345678, {10'd0, 5'd8, 5'd7});
    cyc(1'b1, 1'b1, 1'b0, 4'hF, 5'd8, 32'hAAAAAAAA, {10'd0, 5'd8, 5'd7});
    n = 0;
    for (int k = 0; k < 100; k++) begin
      cyc(1'b1, 1'b0, 1'b1, 4'h0, 5'd0, 32'h0, {10'd0, 5'd8, 5'd7});
      if (!qb0) break;
      n++;
    end
    chk("clr_len", n, 32);
    chk("clr_x7", q0[31:0], 32'h0);
    chk("clr_x8", q0[63:32], 32'h0);

    // clear_i again while the walk sits at counter 10: restart, 32 more cycles
    cyc(1'b1, 1'b1, 1'b1, 4'h0, 5'd0, 32'h0, 20'h0);
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, 1'b1, 4'h0, 5'd0, 32'h0, 20'h0);
    cyc(1'b1, 1'b1, 1'b1, 4'h0, 5'd0, 32'h0, 20'h0);
    n = 0;
    for (int k = 0; k < 100; k++) begin
      cyc(1'b1, 1'b0, 1'b1, 4'h0, 5'd0, 32'h0, 20'h0);
      if (!qb0) break;
      n++;
    end
    chk("clr_restart_len", n, 32);

    // Same-cycle read of the register being written on all four ports
    cyc(1'b1, 1'b0, 1'b0, 4'hF, 5'd3, 32'h11111111, {4{5'd3}});
    cyc(1'b1, 1'b0, 1'b0, 4'hF, 5'd3, 32'hCAFEF00D, {4{5'd3}});
    for (int p = 0; p < 4; p++) begin
`ifdef REGFILE_BYPASS_EN
      chk("byp_write_cycle", q1[p*32 +: 32], 32'hCAFEF00D);
`else
      chk("nobyp_write_cycle", q1[p*32 +: 32], 32'h11111111);
`endif
    end
    cyc(1'b1, 1'b0, 1'b1, 4'h0, 5'd0, 32'h0, {4{5'd3}});
    for (int p = 0; p < 4; p++) chk("after_write", q1[p*32 +: 32], 32'hCAFEF00D);

    // Out-of-range select on the 24-word instance
    cyc(1'b1, 1'b0, 1'b0, 4'hF, 5'd27, 32'h5A5A5A5A, {4{5'd27}});
    cyc(1'b1, 1'b0, 1'b1, 4'h0, 5'd0, 32'h0, {4{5'd27}});
    chk("oor_read", q1[31:0], 32'h0);

    // Reset pulse mid-clear: full 24-cycle walk afterwards
    cyc(1'b0, 1'b0, 1'b1, 4'h0, 5'd0, 32'h0, 20'h0);
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, 1'b1, 4'h0, 5'd0, 32'h0, 20'h0);
    cyc(1'b0, 1'b0, 1'b1, 4'h0, 5'd0, 32'h0, 20'h0);
    n = 0;
    for (int k = 0; k < 100; k++) begin
      cyc(1'b1, 1'b0, 1'b1, 4'h0, 5'd0, 32'h0, 20'h0);
      if (!qb1) break;
      n++;
    end
    chk("rst_mid_len", n, 24);

    // Randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      logic [19:0] s;
      s = {rsel(), rsel(), rsel(), rsel()};
      cyc(1'b1, 1'($urandom_range(0, 99) == 0), 1'($urandom_range(0, 1)),
          4'($urandom_range(0, 15)), rsel(), $urandom, s);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
